camera_capture: RTL and testbench

- Pixel-clock-domain front end that decodes the camera's vsync/href/8-bit byte bus.
- Packs RGB565 pixels into 128-bit words (8 pixels/word) and generates per-word frame-buffer write addresses.
- Rotates among NUM_BUFFERS exposure buffers for HDR and flags completed frames.
- Feeds camera_store: its outputs drive camera_store's p_data/wr_address/last_frame/frame_done/data_valid directly; camera_store writes each word into its clock-crossing FIFO.

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_pixel_packer.sv | 52 +++++
 rtl/camera_capture.sv | 199 +++++++++++++++++++
 tb/tb_camera_capture.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture front end: bus widths, default
// frame geometry and the capture FSM state type.
package cam_pkg;

  localparam int PIXEL_W        = 16;   // RGB565 pixel
  localparam int WORD_W         = 128;  // frame-buffer word, 8 pixels
  localparam int BYTES_PER_WORD = 16;
  localparam int ADDR_W         = 25;   // frame-buffer word address

  localparam int DEF_H_PIXELS     = 640;
  localparam int DEF_V_LINES      = 480;
  localparam int DEF_FRAME_STRIDE = 65536;

  typedef enum logic [1:0] {
    SYNC       = 2'd0,  // waiting for vsync rising edge
    WAIT_FRAME = 2'd1,  // inside vsync pulse, waiting for its falling edge
    CAPTURE    = 2'd2   // packing href bytes into words
  } cap_state_e;

endpackage

// File: rtl/cam_pixel_packer.sv
// Byte-to-word packer for the camera capture path.
// Bytes arrive high byte first; pixel k of a word lands in bits
// [16k+15:16k] with k=0 the first pixel received.
// Ports:
//   clk, rst_n   pixel clock, synchronous active-low reset
//   clear        drop any partial word (frame start / restart)
//   shift_en     byte_in is a valid pixel byte this cycle
//   byte_in      pixel byte
//   word         completed word, valid while word_ready is high
//   word_ready   the byte shifted this cycle completes a word
module cam_pixel_packer
  import cam_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]           byte_cnt;
  logic [7:0]                 hi_byte;
  logic [WORD_W-PIXEL_W-1:0]  pix_sr;   // the 7 most recent whole pixels
  logic [PIXEL_W-1:0]         pixel;

  // The word is presented combinationally on the cycle of its final byte so
  // the top can register it without an extra pipeline stage.
  assign pixel      = {hi_byte, byte_in};
  assign word       = {pixel, pix_sr};
  assign word_ready = shift_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      byte_cnt <= '0;
      hi_byte  <= '0;
      pix_sr   <= '0;
    end else if (shift_en) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
      if (!byte_cnt[0]) begin
        hi_byte <= byte_in;
      end else begin
        // New pixel enters at the top, oldest drops off the bottom.
        pix_sr <= {pixel, pix_sr[WORD_W-PIXEL_W-1:PIXEL_W]};
      end
    end
  end

endmodule

// File: rtl/camera_capture.sv
// Camera pixel-clock front end: decodes vsync/href/byte bus, packs RGB565
// pixels into 128-bit words, generates frame-buffer word addresses and
// rotates among NUM_BUFFERS buffers, flagging completed frames.
// Ports:
//   p_clk, rst_n      pixel clock, synchronous active-low reset
//   cam_vsync         frame sync (frame lies between pulses)
//   cam_href          line valid
//   cam_data          pixel byte, high byte first
//   capture_en        capture enable, sampled at frame start
//   p_data            packed word
//   wr_address        buf_idx*FRAME_STRIDE + word_idx
//   last_frame        most recently completed buffer index
//   frame_done        high with the final word of a complete frame
//   data_valid        one-cycle write strobe
//   frame_err         one-cycle pulse when a malformed frame is dropped
module camera_capture
  import cam_pkg::*;
#(
  parameter int H_PIXELS     = DEF_H_PIXELS,
  parameter int V_LINES      = DEF_V_LINES,
  parameter int NUM_BUFFERS  = 3,
  parameter int FRAME_STRIDE = DEF_FRAME_STRIDE
) (
  input  logic              p_clk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic [WORD_W-1:0] p_data,
  output logic [ADDR_W-1:0] wr_address,
  output logic [2:0]        last_frame,
  output logic              frame_done,
  output logic              data_valid,
  output logic              frame_err
);

  localparam int LINE_BYTES = 2 * H_PIXELS;
  localparam int LB_W       = $clog2(LINE_BYTES + 2);
  localparam int LC_W       = $clog2(V_LINES + 1);

  localparam logic [LB_W-1:0]   LB_FULL  = LB_W'(LINE_BYTES);
  localparam logic [LB_W-1:0]   LB_LAST  = LB_W'(LINE_BYTES - 1);
  localparam logic [LB_W-1:0]   LB_OVER  = LB_W'(LINE_BYTES + 1);
  localparam logic [LC_W-1:0]   LC_LAST  = LC_W'(V_LINES - 1);
  localparam logic [2:0]        BUF_LAST = 3'(NUM_BUFFERS - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(FRAME_STRIDE);

  // Registered camera inputs and their one-cycle-delayed copies for edges.
  logic       vs_r, hr_r, vs_d, hr_d;
  logic [7:0] d_r;
  logic       vs_rise, vs_fall, hr_fall;

  cap_state_e state, state_next;

  logic [LB_W-1:0]   line_bytes;  // saturates at LINE_BYTES+1 on long lines
  logic [LC_W-1:0]   line_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [2:0]        buf_idx;
  logic [ADDR_W-1:0] buf_base;    // running buf_idx*FRAME_STRIDE

  logic              clr, shift_en, byte_inc, line_done, frame_end, err;
  logic [WORD_W-1:0] word;
  logic              word_ready;

  assign vs_rise = vs_r & ~vs_d;
  assign vs_fall = ~vs_r & vs_d;
  assign hr_fall = ~hr_r & hr_d;

  always_ff @(posedge p_clk) begin
    if (!rst_n) begin
      vs_r <= 1'b0;
      hr_r <= 1'b0;
      vs_d <= 1'b0;
      hr_d <= 1'b0;
      d_r  <= '0;
    end else begin
      vs_r <= cam_vsync;
      hr_r <= cam_href;
      vs_d <= vs_r;
      hr_d <= hr_r;
      d_r  <= cam_data;
    end
  end

  cam_pixel_packer u_packer (
    .clk        (p_clk),
    .rst_n      (rst_n),
    .clear      (clr),
    .shift_en   (shift_en),
    .byte_in    (d_r),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge p_clk) begin
    if (!rst_n) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    shift_en   = 1'b0;
    byte_inc   = 1'b0;
    line_done  = 1'b0;
    frame_end  = 1'b0;
    err        = 1'b0;
    unique case (state)
      SYNC: begin
        clr = 1'b1;
        if (vs_rise) state_next = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        clr = 1'b1;
        if (vs_fall) state_next = capture_en ? CAPTURE : SYNC;
      end
      CAPTURE: begin
        if (vs_rise) begin
          err        = 1'b1;
          clr        = 1'b1;
          state_next = WAIT_FRAME;
        end else if (hr_fall && (line_bytes != LB_FULL)) begin
          err        = 1'b1;
          clr        = 1'b1;
          state_next = SYNC;
        end else begin
          line_done = hr_fall;
          byte_inc  = hr_r && (line_bytes != LB_OVER);
          shift_en  = hr_r && (line_bytes < LB_FULL);
          // Every earlier line was exactly LINE_BYTES long (a multiple of 16),
          // so the last byte of the last line always completes a word.
          if (shift_en && (line_cnt == LC_LAST) && (line_bytes == LB_LAST)) begin
            frame_end  = 1'b1;
            state_next = SYNC;
          end
        end
      end
      default: begin
        clr        = 1'b1;
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (!rst_n) begin
      line_bytes <= '0;
      line_cnt   <= '0;
      word_idx   <= '0;
      buf_idx    <= '0;
      buf_base   <= '0;
      p_data     <= '0;
      wr_address <= '0;
      last_frame <= '0;
      frame_done <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (clr) begin
        line_bytes <= '0;
        line_cnt   <= '0;
        word_idx   <= '0;
      end else begin
        if (line_done) begin
          line_bytes <= '0;
          line_cnt   <= line_cnt + LC_W'(1);
        end else if (byte_inc) begin
          line_bytes <= line_bytes + LB_W'(1);
        end
        if (word_ready) word_idx <= word_idx + ADDR_W'(1);
      end

      data_valid <= word_ready;
      frame_done <= frame_end;
      frame_err  <= err;

      if (word_ready) begin
        p_data     <= word;
        wr_address <= buf_base + word_idx;
      end

      if (frame_end) begin
        last_frame <= buf_idx;
        if (buf_idx == BUF_LAST) begin
          buf_idx  <= '0;
          buf_base <= '0;
        end else begin
          buf_idx  <= buf_idx + 3'd1;
          buf_base <= buf_base + STRIDE;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Self-checking bench for camera_capture with a 16x4 frame geometry.
module tb_camera_capture;

  localparam int HP = 16;
  localparam int VL = 4;

  logic         p_clk = 1'b0;
  logic         rst_n;
  logic         cam_vsync;
  logic         cam_href;
  logic [7:0]   cam_data;
  logic         capture_en;
  logic [127:0] p_data;
  logic [24:0]  wr_address;
  logic [2:0]   last_frame;
  logic         frame_done;
  logic         data_valid;
  logic         frame_err;

  camera_capture #(
    .H_PIXELS     (HP),
    .V_LINES      (VL),
    .NUM_BUFFERS  (3),
    .FRAME_STRIDE (65536)
  ) dut (
    .p_clk      (p_clk),
    .rst_n      (rst_n),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .capture_en (capture_en),
    .p_data     (p_data),
    .wr_address (wr_address),
    .last_frame (last_frame),
    .frame_done (frame_done),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  always #5 p_clk = ~p_clk;

  typedef struct {
    bit          cap;       // capture_en at frame start
    bit          seq;       // bytes 0,1,2,... instead of random
    int          bad_line;  // line with wrong length, -1 none
    int          bad_len;
    int          n_lines;   // lines driven before next vsync
    logic [24:0] base;      // expected address of first word
    bit          done;      // frame expected to complete
    logic [2:0]  last;      // expected last_frame on completion
    int          words;     // expected strobe count
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic [24:0]  a;
    logic         fd;
    logic [2:0]   lf;
    int           cyc;
  } obs_t;

  int          total = 0;
  int          bad = 0;
  int          pcyc = 0;
  int          err_cnt = 0;
  int          exp_err = 0;
  bit          trunc_pend = 0;
  int          b15_cyc = 0;
  int          seq_idx = 0;
  logic [7:0]  fb[$];     // accepted bytes of the current frame
  obs_t        obs_q[$];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge p_clk) pcyc <= pcyc + 1;

  // Output monitor: collects strobes, counts error pulses, checks hold rules.
  bit           mon_live = 0;
  bit           have_dv = 0;
  int           last_dv = 0;
  logic [152:0] prev_word;
  logic [2:0]   prev_lf;
  always @(negedge p_clk) begin : monitor
    obs_t o;
    if (rst_n && mon_live) begin
      if (data_valid) begin
        if (have_dv) chk("strobe_gap", 160'((pcyc - last_dv) >= 16), 160'(1));
        have_dv = 1;
        last_dv = pcyc;
        o.d = p_data; o.a = wr_address; o.fd = frame_done; o.lf = last_frame; o.cyc = pcyc;
        obs_q.push_back(o);
      end else begin
        chk("hold_word", 160'({p_data, wr_address}), 160'(prev_word));
      end
      if (!frame_done) chk("hold_last", 160'(last_frame), 160'(prev_lf));
      if (frame_err) err_cnt++;
    end
    prev_word = {p_data, wr_address};
    prev_lf   = last_frame;
    mon_live  = rst_n;
  end

  task automatic put(input logic v, input logic h, input logic [7:0] d);
    @(posedge p_clk);
    #1;
    cam_vsync = v;
    cam_href  = h;
    cam_data  = d;
  endtask

  task automatic drive_line(input int len, input bit acc, input bit seq);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = seq ? 8'(seq_idx) : 8'($urandom);
      seq_idx++;
      put(1'b0, 1'b1, b);
      if (acc) begin
        if (fb.size() == 15) b15_cyc = pcyc;
        fb.push_back(b);
      end
    end
    for (int i = 0; i < 4; i++) put(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync_start(input bit cap);
    capture_en = cap;
    for (int i = 0; i < 3; i++) put(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) put(1'b0, 1'b0, 8'h00);
    capture_en = ~cap;  // must be ignored for the rest of the frame
    for (int i = 0; i < 4; i++) put(1'b0, 1'b0, 8'h00);
  endtask

  // Model rules: pixel byte stream accepted until the frame ends or the first
  // bad line; a vsync arriving mid-capture is reported during the next pulse.
  task automatic run_frame(input vec_t v);
    int len;
    bit acc;
    if (trunc_pend) begin
      exp_err++;
      trunc_pend = 0;
    end
    fb.delete();
    seq_idx = 0;
    vsync_start(v.cap);
    for (int l = 0; l < v.n_lines; l++) begin
      len = (l == v.bad_line) ? v.bad_len : 2 * HP;
      acc = v.cap && (v.bad_line < 0 || l <= v.bad_line);
      drive_line(len, acc, v.seq);
    end
    if (v.bad_line < 0 && v.n_lines == VL) drive_line(2 * HP, 1'b0, 1'b0);
    if (v.cap && v.bad_line >= 0) exp_err++;
    if (v.cap && v.n_lines < VL) trunc_pend = 1;
    for (int i = 0; i < 12; i++) put(1'b0, 1'b0, 8'h00);
  endtask

  function automatic logic [127:0] model_word(input int w);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = {fb[16*w + 2*k], fb[16*w + 2*k + 1]};
    return r;
  endfunction

  task automatic check_frame(input vec_t v);
    bit last_w;
    chk("word_count", 160'(obs_q.size()), 160'(v.words));
    for (int i = 0; i < obs_q.size() && i < v.words; i++) begin
      last_w = v.done && (i == v.words - 1);
      chk("data", 160'(obs_q[i].d), 160'(model_word(i)));
      chk("addr", 160'(obs_q[i].a), 160'(v.base + 25'(i)));
      chk("frame_done", 160'(obs_q[i].fd), 160'(last_w));
      if (last_w) chk("last_frame", 160'(obs_q[i].lf), 160'(v.last));
    end
    chk("frame_err_count", 160'(err_cnt), 160'(exp_err));
    obs_q.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_p_data", 160'(p_data), 160'(0));
    chk("rst_wr_address", 160'(wr_address), 160'(0));
    chk("rst_last_frame", 160'(last_frame), 160'(0));
    chk("rst_frame_done", 160'(frame_done), 160'(0));
    chk("rst_data_valid", 160'(data_valid), 160'(0));
    chk("rst_frame_err", 160'(frame_err), 160'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t         tv[10];
  vec_t         fin;
  logic [127:0] w0_exp;
  int           lat;

  initial begin
    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00; capture_en = 1'b1;
    repeat (3) put(1'b0, 1'b0, 8'h00);
    @(negedge p_clk);
    check_reset_outputs();
    put(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (3) put(1'b0, 1'b0, 8'h00);

    //         cap seq bad len nl  base          done last   words
    tv[0] = '{1, 1, -1, 0,  4, 25'h00000, 1, 3'd0, 8};
    tv[1] = '{1, 0, -1, 0,  4, 25'h10000, 1, 3'd1, 8};
    tv[2] = '{1, 0, -1, 0,  4, 25'h20000, 1, 3'd2, 8};
    tv[3] = '{1, 0, -1, 0,  4, 25'h00000, 1, 3'd0, 8};
    tv[4] = '{1, 0,  2, 30, 4, 25'h10000, 0, 3'd0, 5};
    tv[5] = '{1, 0, -1, 0,  4, 25'h10000, 1, 3'd1, 8};
    tv[6] = '{0, 0, -1, 0,  4, 25'h00000, 0, 3'd0, 0};
    tv[7] = '{1, 0, -1, 0,  4, 25'h20000, 1, 3'd2, 8};
    tv[8] = '{1, 0, -1, 0,  2, 25'h00000, 0, 3'd0, 4};
    tv[9] = '{1, 0, -1, 0,  4, 25'h00000, 1, 3'd0, 8};

    w0_exp = 128'h0e0f_0c0d_0a0b_0809_0607_0405_0203_0001;

    for (int r = 0; r < 10; r++) begin
      run_frame(tv[r]);
      if (r == 0) begin
        lat = -1;
        if (obs_q.size() > 0) begin
          lat = obs_q[0].cyc - b15_cyc;
          chk("word0", 160'(obs_q[0].d), 160'(w0_exp));
        end
        chk("latency", 160'(lat), 160'(2));
      end
      check_frame(tv[r]);
    end

    // Reset in the middle of a captured line, released mid-line.
    fb.delete();
    vsync_start(1'b1);
    drive_line(2 * HP, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) put(1'b0, 1'b1, 8'($urandom));
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) put(1'b0, 1'b1, 8'($urandom));
    @(negedge p_clk);
    check_reset_outputs();
    obs_q.delete();
    put(1'b0, 1'b1, 8'($urandom));
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) put(1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 4; i++) put(1'b0, 1'b0, 8'h00);
    drive_line(2 * HP, 1'b0, 1'b0);
    drive_line(2 * HP, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) put(1'b0, 1'b0, 8'h00);
    chk("no_strobe_after_reset", 160'(obs_q.size()), 160'(0));
    obs_q.delete();
    err_cnt = 0;
    exp_err = 0;
    trunc_pend = 0;

    fin = '{1, 0, -1, 0, 4, 25'h00000, 1, 3'd0, 8};
    run_frame(fin);
    check_frame(fin);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
